// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: shared timing constants for the 640x480@60 VGA generator.
//   VGA_* constants  default porch/sync/active sizes, totals and sync windows
//   cnt_t            10-bit counter type used by all timing comparisons
//   ctl_t            internal (active-high) video/sync flags carried down the delay line
//   in_window()      half-open range test lo <= v < hi at counter width
package vga_timing_pkg;

  localparam int unsigned CNT_W = 10;

  localparam int unsigned VGA_H_ACTIVE = 640;
  localparam int unsigned VGA_H_FP     = 16;
  localparam int unsigned VGA_H_SYNC   = 96;
  localparam int unsigned VGA_H_BP     = 48;
  localparam int unsigned VGA_H_TOTAL  = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;

  localparam int unsigned VGA_V_ACTIVE = 480;
  localparam int unsigned VGA_V_FP     = 10;
  localparam int unsigned VGA_V_SYNC   = 2;
  localparam int unsigned VGA_V_BP     = 33;
  localparam int unsigned VGA_V_TOTAL  = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

  localparam int unsigned VGA_H_SYNC_START = VGA_H_ACTIVE + VGA_H_FP;
  localparam int unsigned VGA_H_SYNC_END   = VGA_H_SYNC_START + VGA_H_SYNC;
  localparam int unsigned VGA_V_SYNC_START = VGA_V_ACTIVE + VGA_V_FP;
  localparam int unsigned VGA_V_SYNC_END   = VGA_V_SYNC_START + VGA_V_SYNC;

  typedef logic [CNT_W-1:0] cnt_t;

  typedef struct packed {
    logic vid;
    logic hs;
    logic vs;
  } ctl_t;

  function automatic logic in_window(input cnt_t v, input cnt_t lo, input cnt_t hi);
    return (v >= lo) && (v < hi);
  endfunction

endpackage

// File: rtl/vga_sync_gen_wrap_counter.sv
// wrap_counter: enabled up-counter that wraps from MAX back to 0.
//   clk   in   rising-edge clock
//   rst   in   asynchronous active-high reset (count -> 0)
//   en    in   count enable
//   cnt   out  current count
//   wrap  out  high while cnt == MAX (independent of en)
module wrap_counter #(
  parameter int unsigned WIDTH = 10,
  parameter int unsigned MAX   = 799
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic [WIDTH-1:0] cnt,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  assign wrap = (cnt_q == MAX_V);
  assign cnt  = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (en) begin
      cnt_d = wrap ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/vga_sync_gen.sv
// vga_sync_gen: 640x480@60 VGA timing generator.
//   pixel_clk    in   clock, all state on rising edge
//   resetSwitch  in   asynchronous active-high reset
//   pixel_ce     in   pixel clock enable; every register holds while low
//   col          out  visible column 0..H_ACTIVE-1, 0 in blanking (1 ce after counters)
//   row          out  visible row 0..V_ACTIVE-1, 0 in blanking (1 ce after counters)
//   video_on     out  visible-pixel flag, PIPE_DLY ce later than col/row
//   hsync        out  horizontal sync, level SYNC_POL when asserted, PIPE_DLY ce later
//   vsync        out  vertical sync, level SYNC_POL when asserted, PIPE_DLY ce later
//   frame_start  out  one-ce pulse alongside col=0,row=0 of every frame
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE = VGA_H_ACTIVE,
  parameter int unsigned H_FP     = VGA_H_FP,
  parameter int unsigned H_SYNC   = VGA_H_SYNC,
  parameter int unsigned H_BP     = VGA_H_BP,
  parameter int unsigned V_ACTIVE = VGA_V_ACTIVE,
  parameter int unsigned V_FP     = VGA_V_FP,
  parameter int unsigned V_SYNC   = VGA_V_SYNC,
  parameter int unsigned V_BP     = VGA_V_BP,
  parameter logic        SYNC_POL = 1'b0,
  parameter int unsigned PIPE_DLY = 1
) (
  input  logic       pixel_clk,
  input  logic       resetSwitch,
  input  logic       pixel_ce,
  output logic [9:0] col,
  output logic [8:0] row,
  output logic       video_on,
  output logic       hsync,
  output logic       vsync,
  output logic       frame_start
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  if (H_TOTAL >= 1024 || V_TOTAL >= 1024 || PIPE_DLY > 3) begin : g_param_check
    $error("vga_sync_gen: totals must stay below 1024 and PIPE_DLY within 0..3");
  end

  localparam cnt_t H_ACT_C = CNT_W'(H_ACTIVE);
  localparam cnt_t V_ACT_C = CNT_W'(V_ACTIVE);
  localparam cnt_t H_SS_C  = CNT_W'(H_ACTIVE + H_FP);
  localparam cnt_t H_SE_C  = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam cnt_t V_SS_C  = CNT_W'(V_ACTIVE + V_FP);
  localparam cnt_t V_SE_C  = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

  cnt_t h_cnt;
  cnt_t v_cnt;
  logic h_wrap;
  logic v_wrap_unused;

  wrap_counter #(.WIDTH(CNT_W), .MAX(H_TOTAL - 1)) u_h_cnt (
    .clk  (pixel_clk),
    .rst  (resetSwitch),
    .en   (pixel_ce),
    .cnt  (h_cnt),
    .wrap (h_wrap)
  );

  wrap_counter #(.WIDTH(CNT_W), .MAX(V_TOTAL - 1)) u_v_cnt (
    .clk  (pixel_clk),
    .rst  (resetSwitch),
    .en   (pixel_ce & h_wrap),
    .cnt  (v_cnt),
    .wrap (v_wrap_unused)
  );

  // Stage 1 decode from the live counters.
  logic [9:0] col_d, col_q;
  logic [8:0] row_d, row_q;
  logic       fs_d, fs_q;
  ctl_t       ctl_d;

  always_comb begin
    col_d     = (h_cnt < H_ACT_C) ? h_cnt : '0;
    // v_cnt < 480 fits in 9 bits, so truncation only happens on the forced-0 path.
    row_d     = (v_cnt < V_ACT_C) ? v_cnt[8:0] : '0;
    fs_d      = (h_cnt == '0) && (v_cnt == '0);
    ctl_d.vid = (h_cnt < H_ACT_C) && (v_cnt < V_ACT_C);
    ctl_d.hs  = in_window(h_cnt, H_SS_C, H_SE_C);
    ctl_d.vs  = in_window(v_cnt, V_SS_C, V_SE_C);
  end

  always_ff @(posedge pixel_clk or posedge resetSwitch) begin
    if (resetSwitch) begin
      col_q <= '0;
      row_q <= '0;
      fs_q  <= 1'b0;
    end else if (pixel_ce) begin
      col_q <= col_d;
      row_q <= row_d;
      fs_q  <= fs_d;
    end
  end

  // Entry 0 is the stage-1 register; entries 1..PIPE_DLY are the extra delay.
  // Flags are held active-high internally, so reset ('0) means deasserted.
  ctl_t pipe_q [PIPE_DLY+1];
  ctl_t pipe_d [PIPE_DLY+1];

  always_comb begin
    pipe_d    = pipe_q;
    pipe_d[0] = ctl_d;
    for (int unsigned i = 1; i <= PIPE_DLY; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
  end

  always_ff @(posedge pixel_clk or posedge resetSwitch) begin
    if (resetSwitch) begin
      for (int unsigned i = 0; i <= PIPE_DLY; i++) begin
        pipe_q[i] <= '0;
      end
    end else if (pixel_ce) begin
      pipe_q <= pipe_d;
    end
  end

  ctl_t ctl_out;
  assign ctl_out     = pipe_q[PIPE_DLY];

  assign col         = col_q;
  assign row         = row_q;
  assign frame_start = fs_q;
  assign video_on    = ctl_out.vid;
  assign hsync       = ctl_out.hs ? SYNC_POL : ~SYNC_POL;
  assign vsync       = ctl_out.vs ? SYNC_POL : ~SYNC_POL;

endmodule

// File: tb/tb_vga_sync_gen.sv
// tb_vga_sync_gen: directed self-checking bench for vga_sync_gen.
//   u_main  : default 640x480 timing, active-low sync, PIPE_DLY=1
//   u_small : reduced 15x10 timing, active-high sync, PIPE_DLY=2 (whole frames fit the run)
module tb_vga_sync_gen;

  typedef struct packed {
    logic [9:0] col;
    logic [8:0] row;
    logic       vid;
    logic       hs;
    logic       vs;
    logic       fs;
  } obs_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_m, ce_m, rst_s, ce_s;
  logic [9:0] col_m, col_s;
  logic [8:0] row_m, row_s;
  logic vid_m, hs_m, vs_m, fs_m;
  logic vid_s, hs_s, vs_s, fs_s;

  obs_t obs_m, obs_s;
  assign obs_m = {col_m, row_m, vid_m, hs_m, vs_m, fs_m};
  assign obs_s = {col_s, row_s, vid_s, hs_s, vs_s, fs_s};

  int total = 0;
  int bad   = 0;
  int k_m   = -1;
  int k_s   = -1;

  vga_sync_gen u_main (
    .pixel_clk   (clk),
    .resetSwitch (rst_m),
    .pixel_ce    (ce_m),
    .col         (col_m),
    .row         (row_m),
    .video_on    (vid_m),
    .hsync       (hs_m),
    .vsync       (vs_m),
    .frame_start (fs_m)
  );

  vga_sync_gen #(
    .H_ACTIVE (8), .H_FP (2), .H_SYNC (3), .H_BP (2),
    .V_ACTIVE (6), .V_FP (1), .V_SYNC (2), .V_BP (1),
    .SYNC_POL (1'b1), .PIPE_DLY (2)
  ) u_small (
    .pixel_clk   (clk),
    .resetSwitch (rst_s),
    .pixel_ce    (ce_s),
    .col         (col_s),
    .row         (row_s),
    .video_on    (vid_s),
    .hsync       (hs_s),
    .vsync       (vs_s),
    .frame_start (fs_s)
  );

  // Expected outputs after the k-th enabled edge since reset release (k<0: in reset).
  // Enabled edge j samples the raster position j counted from the frame origin.
  function automatic obs_t model(input int k, input int hact, input int hfp, input int hsw,
                                 input int hbp, input int vact, input int vfp, input int vsw,
                                 input int vbp, input logic pol, input int dly);
    obs_t e;
    int htot, vtot, h, v;
    htot = hact + hfp + hsw + hbp;
    vtot = vact + vfp + vsw + vbp;
    e = '0;
    e.hs = ~pol;
    e.vs = ~pol;
    if (k < 0) return e;
    h = k % htot;
    v = (k / htot) % vtot;
    e.col = (h < hact) ? 10'(h) : 10'd0;
    e.row = (v < vact) ? 9'(v) : 9'd0;
    e.fs  = (h == 0) && (v == 0);
    if (k >= dly) begin
      h = (k - dly) % htot;
      v = ((k - dly) / htot) % vtot;
      e.vid = (h < hact) && (v < vact);
      e.hs  = (h >= hact + hfp && h < hact + hfp + hsw) ? pol : ~pol;
      e.vs  = (v >= vact + vfp && v < vact + vfp + vsw) ? pol : ~pol;
    end
    return e;
  endfunction

  function automatic obs_t exp_main(input int k);
    return model(k, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1);
  endfunction

  function automatic obs_t exp_small(input int k);
    return model(k, 8, 2, 3, 2, 6, 1, 2, 1, 1'b1, 2);
  endfunction

  task automatic tick(input logic rm, input logic cm, input logic rs, input logic cs);
    @(negedge clk);
    rst_m = rm; ce_m = cm; rst_s = rs; ce_s = cs;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      tick(1'b1, 1'b1, 1'b1, 1'b1);
      total++;
      if (obs_m !== exp_main(-1)) begin
        bad++;
        $display("FAIL reset_main cyc=%0d got=%h exp=%h", i, obs_m, exp_main(-1));
      end
      total++;
      if (obs_s !== exp_small(-1)) begin
        bad++;
        $display("FAIL reset_small cyc=%0d got=%h exp=%h", i, obs_s, exp_small(-1));
      end
    end
  endtask

  task automatic test_line();
    int vid_cnt = 0, hs_cnt = 0, fs_cnt = 0, first_hs = -1;
    k_m = -1;
    for (int i = 0; i < 1600; i++) begin
      tick(1'b0, 1'b1, 1'b1, 1'b1);
      k_m++;
      total++;
      if (obs_m !== exp_main(k_m)) begin
        bad++;
        $display("FAIL line k=%0d got=%h exp=%h", k_m, obs_m, exp_main(k_m));
      end
      if (k_m < 800) begin
        if (vid_m === 1'b1) vid_cnt++;
        if (fs_m === 1'b1) fs_cnt++;
        if (hs_m === 1'b0) begin
          hs_cnt++;
          if (first_hs < 0) first_hs = k_m;
        end
      end
      if (k_m == 800) begin
        total++;
        if (row_m !== 9'd1) begin
          bad++;
          $display("FAIL row_wrap got=%0d exp=1", row_m);
        end
      end
    end
    total++;
    if (vid_cnt != 640) begin bad++; $display("FAIL video_on_len got=%0d exp=640", vid_cnt); end
    total++;
    if (hs_cnt != 96) begin bad++; $display("FAIL hsync_len got=%0d exp=96", hs_cnt); end
    total++;
    if (first_hs != 657) begin bad++; $display("FAIL hsync_start got=%0d exp=657", first_hs); end
    total++;
    if (fs_cnt != 1) begin bad++; $display("FAIL fs_per_line got=%0d exp=1", fs_cnt); end
  endtask

  task automatic test_ce_toggle_main();
    for (int i = 0; i < 200; i++) begin
      tick(1'b0, (i % 2 == 0), 1'b1, 1'b1);
      if (i % 2 == 0) k_m++;
      total++;
      if (obs_m !== exp_main(k_m)) begin
        bad++;
        $display("FAIL ce_toggle_main i=%0d k=%0d got=%h exp=%h", i, k_m, obs_m, exp_main(k_m));
      end
    end
  endtask

  task automatic test_mid_reset_main();
    int guard = 0;
    // counters sit at h=300 once k_m+1 == 2700
    while (k_m != 2699 && guard < 2000) begin
      tick(1'b0, 1'b1, 1'b1, 1'b1);
      k_m++;
      guard++;
      total++;
      if (obs_m !== exp_main(k_m)) begin
        bad++;
        $display("FAIL pre_reset_main k=%0d got=%h exp=%h", k_m, obs_m, exp_main(k_m));
      end
    end
    total++;
    if (k_m != 2699) begin bad++; $display("FAIL reach_h300 got=%0d exp=2699", k_m); end
    #2 rst_m = 1'b1;
    #1;
    total++;
    if (obs_m !== exp_main(-1)) begin
      bad++;
      $display("FAIL async_reset_main got=%h exp=%h", obs_m, exp_main(-1));
    end
    for (int i = 0; i < 2; i++) begin
      tick(1'b1, 1'b1, 1'b1, 1'b1);
      total++;
      if (obs_m !== exp_main(-1)) begin
        bad++;
        $display("FAIL hold_reset_main got=%h exp=%h", obs_m, exp_main(-1));
      end
    end
    k_m = -1;
    for (int i = 0; i < 6; i++) begin
      tick(1'b0, 1'b1, 1'b1, 1'b1);
      k_m++;
      total++;
      if (obs_m !== exp_main(k_m)) begin
        bad++;
        $display("FAIL restart_main k=%0d got=%h exp=%h", k_m, obs_m, exp_main(k_m));
      end
    end
  endtask

  task automatic test_frame_small();
    int vs_cnt = 0, fs_cnt = 0;
    k_s = -1;
    for (int i = 0; i < 450; i++) begin
      tick(1'b1, 1'b1, 1'b0, 1'b1);
      k_s++;
      total++;
      if (obs_s !== exp_small(k_s)) begin
        bad++;
        $display("FAIL frame_small k=%0d got=%h exp=%h", k_s, obs_s, exp_small(k_s));
      end
      if (k_s < 150 && vs_s === 1'b1) vs_cnt++;
      if (fs_s === 1'b1) fs_cnt++;
    end
    total++;
    if (vs_cnt != 30) begin bad++; $display("FAIL vsync_len got=%0d exp=30", vs_cnt); end
    total++;
    if (fs_cnt != 3) begin bad++; $display("FAIL fs_per_3frames got=%0d exp=3", fs_cnt); end
  endtask

  task automatic test_ce_toggle_small();
    int fs_high = 0, rises = 0, last_rise = -1, period = -1;
    logic prev_fs = 1'b0;
    for (int c = 0; c < 600; c++) begin
      tick(1'b1, 1'b1, 1'b0, (c % 2 == 0));
      if (c % 2 == 0) k_s++;
      total++;
      if (obs_s !== exp_small(k_s)) begin
        bad++;
        $display("FAIL ce_toggle_small c=%0d k=%0d got=%h exp=%h", c, k_s, obs_s, exp_small(k_s));
      end
      if (fs_s === 1'b1) fs_high++;
      if (fs_s === 1'b1 && prev_fs !== 1'b1) begin
        rises++;
        if (last_rise >= 0) period = c - last_rise;
        last_rise = c;
      end
      prev_fs = fs_s;
    end
    total++;
    if (fs_high != 4) begin bad++; $display("FAIL fs_window got=%0d exp=4", fs_high); end
    total++;
    if (rises != 2) begin bad++; $display("FAIL fs_rises got=%0d exp=2", rises); end
    total++;
    if (period != 300) begin bad++; $display("FAIL frame_period got=%0d exp=300", period); end
  endtask

  task automatic test_back_to_back_small();
    int guard = 0;
    // counters at h=5,v=3 once k_s+1 == 800
    while (k_s != 799 && guard < 200) begin
      tick(1'b1, 1'b1, 1'b0, 1'b1);
      k_s++;
      guard++;
      total++;
      if (obs_s !== exp_small(k_s)) begin
        bad++;
        $display("FAIL pre_reset_small k=%0d got=%h exp=%h", k_s, obs_s, exp_small(k_s));
      end
    end
    total++;
    if (k_s != 799) begin bad++; $display("FAIL reach_mid_small got=%0d exp=799", k_s); end
    #2 rst_s = 1'b1;
    #1;
    total++;
    if (obs_s !== exp_small(-1)) begin
      bad++;
      $display("FAIL async_reset_small got=%h exp=%h", obs_s, exp_small(-1));
    end
    tick(1'b1, 1'b1, 1'b1, 1'b1);
    total++;
    if (obs_s !== exp_small(-1)) begin
      bad++;
      $display("FAIL hold_reset_small got=%h exp=%h", obs_s, exp_small(-1));
    end
    k_s = -1;
    for (int i = 0; i < 40; i++) begin
      tick(1'b1, 1'b1, 1'b0, 1'b1);
      k_s++;
      total++;
      if (obs_s !== exp_small(k_s)) begin
        bad++;
        $display("FAIL restart_small k=%0d got=%h exp=%h", k_s, obs_s, exp_small(k_s));
      end
    end
  endtask

  initial begin
    rst_m = 1'b1; ce_m = 1'b1; rst_s = 1'b1; ce_s = 1'b1;
    test_reset();
    test_line();
    test_ce_toggle_main();
    test_mid_reset_main();
    test_frame_small();
    test_ce_toggle_small();
    test_back_to_back_small();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
